// File: rtl/mips_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit: operation codes and FSM states.
// Also used by the core's instruction decoder.
package mips_muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   function automatic logic op_is_div(input op_e o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO unit: one bit per cycle shift-add multiply / restoring divide on
// operand magnitudes, followed by a single sign-fixup cycle.
module mips_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_r, state_next_s;
   op_e                op_r;
   logic               busy_r, done_r, dbz_r;
   logic [WIDTH-1:0]   rs_r, rt_r, a_mag_r, b_mag_r, hi_r, lo_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [CW-1:0]      cnt_r;

   logic               in_signed_s, rs_neg_s, rt_neg_s, res_neg_s;
   logic [WIDTH-1:0]   rs_mag_s, rt_mag_s, quot_s, rem_s, res_hi_s, res_lo_s;
   logic [WIDTH:0]     add_a_s, add_b_s, add_sum_s;
   logic               sub_s;

   // Operand magnitudes presented at the accepting edge.
   always_comb begin
      in_signed_s = op_is_signed(op_e'(op));
      rs_mag_s    = (in_signed_s && rs_val[WIDTH-1]) ? -rs_val : rs_val;
      rt_mag_s    = (in_signed_s && rt_val[WIDTH-1]) ? -rt_val : rt_val;
   end

   // Shared adder: accumulate multiplicand, or trial-subtract divisor from the shifted remainder.
   always_comb begin
      sub_s = op_is_div(op_r);
      if (sub_s) begin
         add_a_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
         add_b_s = ~{1'b0, b_mag_r};
      end else begin
         add_a_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
         add_b_s = acc_r[0] ? {1'b0, a_mag_r} : {(WIDTH+1){1'b0}};
      end
      add_sum_s = add_a_s + add_b_s + {{WIDTH{1'b0}}, sub_s};
   end

   // Sign restoration of the magnitude result; zero divisor bypasses the datapath.
   always_comb begin
      rs_neg_s  = op_is_signed(op_r) && rs_r[WIDTH-1];
      rt_neg_s  = op_is_signed(op_r) && rt_r[WIDTH-1];
      res_neg_s = rs_neg_s ^ rt_neg_s;
      quot_s    = acc_r[WIDTH-1:0];
      rem_s     = acc_r[2*WIDTH-1:WIDTH];
      if (op_is_div(op_r)) begin
         if (rt_r == {WIDTH{1'b0}}) begin
            res_hi_s = rs_r;
            res_lo_s = {WIDTH{1'b1}};
         end else begin
            res_hi_s = rs_neg_s  ? -rem_s  : rem_s;
            res_lo_s = res_neg_s ? -quot_s : quot_s;
         end
      end else begin
         {res_hi_s, res_lo_s} = res_neg_s ? -acc_r : acc_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_next_s = ST_CALC;
            else       state_next_s = ST_IDLE;
         end
         ST_CALC: begin
            if (cnt_r == CW'(WIDTH-1)) state_next_s = ST_FIX;
            else                       state_next_s = ST_CALC;
         end
         ST_FIX:  state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State register with registered busy flag.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != ST_IDLE);
      end
   end

   // Operand latch, iteration datapath, HI/LO registers and status flags.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         op_r    <= OP_MULT;
         rs_r    <= {WIDTH{1'b0}};
         rt_r    <= {WIDTH{1'b0}};
         a_mag_r <= {WIDTH{1'b0}};
         b_mag_r <= {WIDTH{1'b0}};
         acc_r   <= {(2*WIDTH){1'b0}};
         cnt_r   <= {CW{1'b0}};
         hi_r    <= {WIDTH{1'b0}};
         lo_r    <= {WIDTH{1'b0}};
         done_r  <= 1'b0;
         dbz_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (hi_we) hi_r <= wdata;
               if (lo_we) lo_r <= wdata;
               if (start) begin
                  op_r    <= op_e'(op);
                  rs_r    <= rs_val;
                  rt_r    <= rt_val;
                  a_mag_r <= rs_mag_s;
                  b_mag_r <= rt_mag_s;
                  // Low half holds the multiplier (MULT*) or the dividend (DIV*).
                  acc_r   <= {{WIDTH{1'b0}}, op_is_div(op_e'(op)) ? rs_mag_s : rt_mag_s};
                  cnt_r   <= {CW{1'b0}};
                  dbz_r   <= 1'b0;
               end
            end
            ST_CALC: begin
               cnt_r <= cnt_r + CW'(1);
               if (sub_s) begin
                  if (!add_sum_s[WIDTH]) acc_r <= {add_sum_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
                  else                   acc_r <= {acc_r[2*WIDTH-2:0], 1'b0};
               end else begin
                  acc_r <= {add_sum_s, acc_r[WIDTH-1:1]};
               end
            end
            ST_FIX: begin
               hi_r   <= res_hi_s;
               lo_r   <= res_lo_s;
               dbz_r  <= op_is_div(op_r) && (rt_r == {WIDTH{1'b0}});
               done_r <= 1'b1;
            end
            default: done_r <= 1'b0;
         endcase
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign hi          = hi_r;
   assign lo          = lo_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv (WIDTH = 32): arithmetic reference model checked every cycle,
// plus directed operations with hand-computed HI/LO values.
module tb_mips_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n, start, hi_we, lo_we;
   logic [1:0]   op;
   logic [W-1:0] rs_val, rt_val, wdata;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mips_muldiv #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Reference arithmetic: returns {div_by_zero, hi, lo}.
   function automatic logic [2*W:0] model_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up;
      logic [W-1:0]    q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'b00: begin sp = sa * sb; return {1'b0, sp[63:0]}; end
         2'b01: begin up = ua * ub; return {1'b0, up[63:0]}; end
         2'b10: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            sq = sa / sb; sr = sa % sb;
            q = sq[31:0]; r = sr[31:0];
            return {1'b0, r, q};
         end
         default: begin
            if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
            up = ua / ub; q = up[31:0];
            up = ua % ub; r = up[31:0];
            return {1'b0, r, q};
         end
      endcase
   endfunction

   logic         m_busy, m_done, m_dbz;
   logic [W-1:0] m_hi, m_lo;
   logic [2*W:0] m_res;
   int           m_left;

   always @(posedge clk) begin
      if (rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (hi_we) m_hi <= wdata;
            if (lo_we) m_lo <= wdata;
            if (start) begin
               m_busy <= 1'b1;
               m_dbz  <= 1'b0;
               m_res  <= model_result(op, rs_val, rt_val);
               m_left <= W;
            end
         end else if (m_left == 0) begin
            {m_dbz, m_hi, m_lo} <= m_res;
            m_done <= 1'b1;
            m_busy <= 1'b0;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {63'd0, busy}, {63'd0, m_busy});
         chk("done", {63'd0, done}, {63'd0, m_done});
         chk("dbz",  {63'd0, div_by_zero}, {63'd0, m_dbz});
         chk("hi",   {32'd0, hi}, {32'd0, m_hi});
         chk("lo",   {32'd0, lo}, {32'd0, m_lo});
      end
   end

   task automatic wait_done(output int dcyc);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) chk("done_timeout", {63'd0, done}, 64'd1);
      dcyc = cyc;
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input logic exp_dbz);
      int s, d;
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b; s = cyc;
      @(negedge clk);
      start = 1'b0; rs_val = ~a; rt_val = ~b;
      wait_done(d);
      chk({name, "_hi"},  {32'd0, hi}, {32'd0, exp_hi});
      chk({name, "_lo"},  {32'd0, lo}, {32'd0, exp_lo});
      chk({name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_dbz});
      chk({name, "_lat"}, 64'(d - s), 64'd34);
      @(negedge clk);
   endtask

   int d_unused;
   int done_cnt;

   initial begin
      rst_n = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_hi",   {32'd0, hi}, 64'd0);
      chk("rst_lo",   {32'd0, lo}, 64'd0);
      rst_n = 1'b0;

      // MTHI / MTLO while idle
      @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0F0F_1234;
      @(negedge clk); lo_we = 1'b0;
      chk("mthi", {32'd0, hi}, 64'h0000_0000_A5A5_A5A5);
      chk("mtlo", {32'd0, lo}, 64'h0000_0000_0F0F_1234);

      run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_negd",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_7_2",  2'b11, 32'd7,         32'd2,        32'h0000_0001, 32'h0000_0003, 1'b0);
      run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
      run_op("div_zero",  2'b10, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      run_op("divu_zero", 2'b11, 32'h8000_0001, 32'd0,        32'h8000_0001, 32'hFFFF_FFFF, 1'b1);

      // start together with MTHI on the accepting edge: write visible while busy, then overwritten
      @(negedge clk);
      start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd5; hi_we = 1'b1; wdata = 32'h0000_BEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      chk("we_on_start", {32'd0, hi}, 64'h0000_0000_0000_BEEF);
      repeat (4) @(negedge clk);
      // cycle 5 of the busy operation: these must be ignored
      start = 1'b1; op = 2'b10; rs_val = 32'd100; rt_val = 32'd3; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_DEAD;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      chk("busy_we_hi", {32'd0, hi}, 64'h0000_0000_0000_BEEF);
      wait_done(d_unused);
      chk("ignore_hi", {32'd0, hi}, 64'd0);
      chk("ignore_lo", {32'd0, lo}, 64'd15);
      @(negedge clk);
      chk("no_restart", {63'd0, busy}, 64'd0);

      // reset at cycle 10 of an operation
      @(negedge clk);
      start = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_hi",   {32'd0, hi}, 64'd0);
      chk("midrst_lo",   {32'd0, lo}, 64'd0);
      done_cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      chk("midrst_nodone", 64'(done_cnt), 64'd0);
      chk("midrst_lo_hold", {32'd0, lo}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width (legal: even, >= 8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-high (asserted when 1).
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only while idle.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs_val  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port rt_val  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port hi_we  input  1  MTHI write strobe.
REQ-009 SHALL have port lo_we  input  1  MTLO write strobe.
REQ-010 SHALL have port wdata  input  WIDTH  MTHI/MTLO write data.
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port hi  output  WIDTH  HI register (MFHI source).
REQ-014 SHALL have port lo  output  WIDTH  LO register (MFLO source).
REQ-015 SHALL have port div_by_zero  output  1  last division had rt_val == 0.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, FIX; busy = 1 in CALC and FIX, 0 in IDLE.
REQ-017 SHALL, in IDLE with start = 1 at edge k, latch operands and op, clear the iteration counter, clear div_by_zero, and enter CALC.
REQ-018 SHALL iterate one bit per cycle in CALC for exactly WIDTH cycles (edges k+1 .. k+WIDTH), then enter FIX.
REQ-019 SHALL, at edge k+WIDTH+1 (FIX), write the results to hi/lo, drive done = 1 for exactly that following cycle, and return to IDLE.
REQ-020 SHALL use shift-add multiplication on magnitudes, with {hi,lo} = full 2*WIDTH product (signed two's complement for MULT, unsigned for MULTU).
REQ-021 SHALL use restoring division on magnitudes, with lo = quotient and hi = remainder; signed quotient truncates toward zero, and the signed remainder takes the sign of the dividend.
REQ-022 SHALL, for a division with rt_val == 0, set hi = rs_val, lo = all ones, and div_by_zero = 1, with unchanged latency.
REQ-023 SHALL, for DIV of the most-negative value by -1, produce lo = most-negative value and hi = 0 without error.
REQ-024 SHALL ignore start while busy; the latched operands are not disturbed.
REQ-025 SHALL ignore hi_we/lo_we while busy.
REQ-026 SHALL apply hi_we/lo_we in IDLE on the same edge, including the edge that accepts start; the write is overwritten by the result at completion.
REQ-027 SHALL hold hi, lo and div_by_zero stable except on the events in REQ-017, REQ-019, REQ-022 and REQ-026.

Reset
REQ-028 SHALL, when rst_n = 1 at a clock edge, force state IDLE, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, and counter = 0.
REQ-029 SHALL, on reset mid-operation, abandon the operation: no done pulse is issued and hi/lo are not updated.
REQ-030 SHALL give reset priority over start, hi_we and lo_we.

Structure
REQ-031 SHALL place the op encoding and FSM state typedefs in shared package mips_muldiv_pkg, for reuse by the core's decoder.
REQ-032 SHALL be a single module with no sub-module; the FSM, counter and shared add/subtract datapath share one always block set.

Verification (WIDTH = 32)
REQ-033 SHALL check MULT rs = 0xFFFFFFFD, rt = 7: done 34 cycles after the start cycle, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-034 SHALL check MULTU 0xFFFFFFFF x 0xFFFFFFFF: hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-035 SHALL check DIV rs = 0xFFFFFFF9 (-7), rt = 2: lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; and DIVU 7 / 2: lo = 3, hi = 1.
REQ-036 SHALL check division by zero: DIV rs = 0x12345678, rt = 0: hi = 0x12345678, lo = 0xFFFFFFFF, div_by_zero = 1.
REQ-037 SHALL check DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-038 SHALL check that a start plus hi_we issued at cycle 5 of a busy operation are ignored, and that rst_n = 1 at cycle 10 yields busy = 0, hi = lo = 0, and no done pulse.
